calibration_engine_mc: RTL and testbench

Multi-channel, fully pipelined successor to the single-channel calibration engine. It applies a per-channel signed offset, a per-channel unsigned fixed-point gain, and clamp/saturation to a time-multiplexed sensor sample stream. Samples enter with a channel tag, and every lane is accepted each cycle, with no idle/busy gap. The block sits between the sensor front-end mux and the downstream filtering/security checks. It keeps per-channel coefficient banks and saturation statistics.

---
 rtl/calibration_engine_mc.sv | 211 +++++++++++++++++++++
 tb/tb_calibration_engine_mc.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calibration_engine_mc.sv
// Multi-channel calibration engine: per-channel offset, fixed-point gain and clamp over a 3-stage stallable pipeline.
// Build option CAL_ROUNDING_EN selects round-half-up in the scale stage; truncation otherwise.
module calibration_engine_mc #(
    parameter int DATA_WIDTH     = 16,
    parameter int GAIN_FRAC_BITS = 12,
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_WIDTH       = $clog2(NUM_CHANNELS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [CH_WIDTH-1:0]   cfg_ch,
    input  logic [DATA_WIDTH-1:0] cfg_offset,
    input  logic [DATA_WIDTH-1:0] cfg_gain,
    input  logic                  cfg_bypass,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CH_WIDTH-1:0]   in_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_WIDTH-1:0]   out_ch,
    output logic                  out_sat,
    input  logic [CH_WIDTH-1:0]   sat_sel,
    input  logic                  sat_clear,
    output logic [15:0]           sat_count
);
    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH + 2;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [DW-1:0] GAIN_ONE = {{(DW-1){1'b0}}, 1'b1} << GAIN_FRAC_BITS;
`ifdef CAL_ROUNDING_EN
    localparam logic [PW-1:0] ROUND_HALF = {{(PW-1){1'b0}}, 1'b1} << (GAIN_FRAC_BITS - 1);
`endif

    // Returns {sat, clamped}; sum is never outside [-2^DW, 2^(DW+1)).
    function automatic logic [DW:0] clamp_offset(input logic signed [SW-1:0] sum);
        if (sum[SW-1]) return {1'b1, {DW{1'b0}}};
        if (sum[DW])   return {1'b1, {DW{1'b1}}};
        return {1'b0, sum[DW-1:0]};
    endfunction

    function automatic logic [DW:0] scale_product(input logic [PW-1:0] prod);
        logic [PW-1:0] r;
        r = prod;
`ifdef CAL_ROUNDING_EN
        r = prod + ROUND_HALF;
`endif
        if (|r[PW-1:DW+GAIN_FRAC_BITS]) return {1'b1, {DW{1'b1}}};
        return {1'b0, r[DW+GAIN_FRAC_BITS-1:GAIN_FRAC_BITS]};
    endfunction

    logic signed [DW-1:0] off_q  [NUM_CHANNELS];
    logic signed [DW-1:0] off_d  [NUM_CHANNELS];
    logic [DW-1:0]        gain_q [NUM_CHANNELS];
    logic [DW-1:0]        gain_d [NUM_CHANNELS];
    logic                 byp_q  [NUM_CHANNELS];
    logic                 byp_d  [NUM_CHANNELS];
    logic [15:0]          cnt_q  [NUM_CHANNELS];
    logic [15:0]          cnt_d  [NUM_CHANNELS];

    logic                 adv;
    logic signed [DW-1:0] sel_off;
    logic [DW-1:0]        sel_gain;
    logic                 sel_byp;
    logic                 ch_ok;
    logic signed [SW-1:0] sum_p0;
    logic [DW:0]          clamp_p0;
    logic [DW:0]          scale_p2;

    logic                vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, out_valid_q, out_valid_d;
    logic [DW-1:0]       data_p1_q, data_p1_d, gain_p1_q, gain_p1_d;
    logic                sat_p1_q, sat_p1_d, sat_p2_q, sat_p2_d, out_sat_q, out_sat_d;
    logic [CH_WIDTH-1:0] ch_p1_q, ch_p1_d, ch_p2_q, ch_p2_d, out_ch_q, out_ch_d;
    logic [PW-1:0]       prod_p2_q, prod_p2_d;
    logic [DW-1:0]       out_data_q, out_data_d;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        off_d  = off_q;
        gain_d = gain_q;
        byp_d  = byp_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (cfg_we && int'(cfg_ch) == i) begin
                off_d[i]  = $signed(cfg_offset);
                gain_d[i] = cfg_gain;
                byp_d[i]  = cfg_bypass;
            end
        end
    end

    always_comb begin
        sel_off  = '0;
        sel_gain = GAIN_ONE;
        sel_byp  = 1'b0;
        ch_ok    = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (int'(in_ch) == i) begin
                sel_off  = off_q[i];
                sel_gain = gain_q[i];
                sel_byp  = byp_q[i];
                ch_ok    = 1'b1;
            end
        end
    end

    // S1: offset and clamp; bypass swaps in unity gain so later stages pass the sample through
    always_comb begin
        sum_p0   = $signed({2'b00, in_data}) + $signed({{2{sel_off[DW-1]}}, sel_off});
        clamp_p0 = clamp_offset(sum_p0);
        vld_p1_d = in_valid && ch_ok;
        ch_p1_d  = in_ch;
        if (sel_byp) begin
            data_p1_d = in_data;
            sat_p1_d  = 1'b0;
            gain_p1_d = GAIN_ONE;
        end else begin
            data_p1_d = clamp_p0[DW-1:0];
            sat_p1_d  = clamp_p0[DW];
            gain_p1_d = sel_gain;
        end
    end

    // S2: gain multiply
    always_comb begin
        vld_p2_d  = vld_p1_q;
        ch_p2_d   = ch_p1_q;
        sat_p2_d  = sat_p1_q;
        prod_p2_d = PW'(data_p1_q) * PW'(gain_p1_q);
    end

    // S3: scale back to sample width and saturate
    always_comb begin
        scale_p2    = scale_product(prod_p2_q);
        out_valid_d = vld_p2_q;
        out_ch_d    = ch_p2_q;
        out_data_d  = scale_p2[DW-1:0];
        out_sat_d   = sat_p2_q | scale_p2[DW];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_ff @(posedge clock) begin
        if (adv) begin
            data_p1_q <= data_p1_d;
            gain_p1_q <= gain_p1_d;
            sat_p1_q  <= sat_p1_d;
            ch_p1_q   <= ch_p1_d;
            prod_p2_q <= prod_p2_d;
            sat_p2_q  <= sat_p2_d;
            ch_p2_q   <= ch_p2_d;
        end
    end

    // Clear is applied after the increment so it wins on a same-cycle collision.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (out_valid_q && out_ready && out_sat_q && int'(out_ch_q) == i && cnt_q[i] != 16'hFFFF)
                cnt_d[i] = cnt_q[i] + 16'd1;
            if (sat_clear && int'(sat_sel) == i)
                cnt_d[i] = '0;
        end
    end

    always_comb begin
        sat_count = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (int'(sat_sel) == i) sat_count = cnt_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                off_q[i]  <= '0;
                gain_q[i] <= GAIN_ONE;
                byp_q[i]  <= 1'b0;
                cnt_q[i]  <= '0;
            end
        end else begin
            off_q  <= off_d;
            gain_q <= gain_d;
            byp_q  <= byp_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_calibration_engine_mc.sv
// Scoreboard bench for calibration_engine_mc: directed vectors push expectations, a monitor pops on each output transfer.
module tb_calibration_engine_mc;
    localparam int DW  = 16;
    localparam int CHW = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [DW-1:0]  cfg_offset;
    logic [DW-1:0]  cfg_gain;
    logic           cfg_bypass;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [CHW-1:0] in_ch;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [CHW-1:0] out_ch;
    logic           out_sat;
    logic [CHW-1:0] sat_sel;
    logic           sat_clear;
    logic [15:0]    sat_count;

    calibration_engine_mc #(.DATA_WIDTH(DW), .GAIN_FRAC_BITS(12), .NUM_CHANNELS(4)) dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_offset(cfg_offset), .cfg_gain(cfg_gain), .cfg_bypass(cfg_bypass),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
        .sat_sel(sat_sel), .sat_clear(sat_clear), .sat_count(sat_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0]  data;
        logic [CHW-1:0] ch;
        logic           sat;
        int             exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sample is accepted.
    task automatic send(input logic [CHW-1:0] ch, input logic [DW-1:0] d, input logic [DW-1:0] exp_d,
                        input logic exp_sat, input bit lat, input bit push);
        int   g;
        exp_t e;
        g = 0;
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        #1;
        while (!in_ready && g < 100) begin
            @(negedge clock);
            #1;
            g++;
        end
        if (g >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
        if (push) begin
            e.data    = exp_d;
            e.ch      = ch;
            e.sat     = exp_sat;
            e.exp_cyc = lat ? cyc + 3 : -1;
            sb.push_back(e);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [CHW-1:0] ch, input logic [DW-1:0] off, input logic [DW-1:0] gain,
                             input logic byp);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_offset = off;
        cfg_gain   = gain;
        cfg_bypass = byp;
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clock);
            g++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        @(negedge clock);
    endtask

    task automatic chk_cnt(input logic [CHW-1:0] ch, input logic [15:0] exp, input string name);
        sat_sel = ch;
        #1;
        chk(name, 32'(sat_count), 32'(exp));
        @(negedge clock);
    endtask

    logic           prev_stall = 1'b0;
    logic [DW-1:0]  prev_data;
    logic [CHW-1:0] prev_ch;
    logic           prev_sat;

    always @(negedge clock) begin
        exp_t e;
        #1;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_ch", 32'(out_ch), 32'(prev_ch));
                chk("hold_sat", 32'(out_sat), 32'(prev_sat));
            end
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data 0x%0h ch %0d with nothing expected", out_data, out_ch);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_ch", 32'(out_ch), 32'(e.ch));
                    chk("out_sat", 32'(out_sat), 32'(e.sat));
                    if (e.exp_cyc >= 0) chk("latency", cyc, e.exp_cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ch    = out_ch;
            prev_sat   = out_sat;
        end
    end

    initial begin
        repeat (90000) @(posedge clock);
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    localparam logic [DW-1:0] RND_3 =
`ifdef CAL_ROUNDING_EN
        16'h0002;
`else
        16'h0001;
`endif

    initial begin
        int g;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_offset = '0; cfg_gain = '0; cfg_bypass = 1'b0;
        in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1; sat_sel = '0; sat_clear = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        @(negedge clock);

        // identity after reset, latency 3
        send(2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
        drain();

        // offset + gain, negative clamp
        cfg_write(2'd2, 16'h0010, 16'h1800, 1'b0);
        cfg_write(2'd3, 16'hFF00, 16'h1000, 1'b0);
        send(2'd2, 16'h0100, 16'h0198, 1'b0, 1'b1, 1'b1);
        send(2'd3, 16'h0050, 16'h0000, 1'b1, 1'b1, 1'b1);
        drain();
        chk_cnt(2'd3, 16'd1, "cnt_ch3_after_clamp");

        // gain overflow, then bypass
        cfg_write(2'd1, 16'h0000, 16'h2000, 1'b0);
        send(2'd1, 16'h9000, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        drain();
        cfg_write(2'd1, 16'h0000, 16'h2000, 1'b1);
        send(2'd1, 16'h9000, 16'h9000, 1'b0, 1'b0, 1'b1);
        drain();
        chk_cnt(2'd1, 16'd1, "cnt_ch1_after_bypass");

        // back-to-back stream with a 5-cycle output stall
        fork
            begin
                send(2'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
                send(2'd1, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1);
                send(2'd2, 16'h0200, 16'h0318, 1'b0, 1'b0, 1'b1);
                send(2'd3, 16'h0300, 16'h0200, 1'b0, 1'b0, 1'b1);
                send(2'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
                send(2'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
                send(2'd2, 16'h1000, 16'h1818, 1'b0, 1'b0, 1'b1);
                send(2'd3, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1);
            end
            begin
                repeat (3) @(negedge clock);
                out_ready = 1'b0;
                repeat (5) @(negedge clock);
                out_ready = 1'b1;
            end
        join
        drain();
        chk_cnt(2'd3, 16'd1, "cnt_ch3_after_stream");

        // gain 0.5 rounding
        cfg_write(2'd0, 16'h0000, 16'h0800, 1'b0);
        send(2'd0, 16'h0003, RND_3, 1'b0, 1'b0, 1'b1);
        send(2'd0, 16'h0004, 16'h0002, 1'b0, 1'b0, 1'b1);
        drain();

        // coefficient write in the transfer cycle uses the old gain
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_offset = 16'h0000; cfg_gain = 16'h1000; cfg_bypass = 1'b0;
        send(2'd0, 16'h0008, 16'h0004, 1'b0, 1'b0, 1'b1);
        cfg_we = 1'b0;
        send(2'd0, 16'h0008, 16'h0008, 1'b0, 1'b0, 1'b1);
        drain();

        // mid-stream reset flushes and restores defaults
        send(2'd2, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(2'd3, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("flush_out_valid", 32'(out_valid), 32'd0);
            @(negedge clock);
        end
        chk_cnt(2'd3, 16'd0, "cnt_ch3_after_reset");
        chk_cnt(2'd1, 16'd0, "cnt_ch1_after_reset");
        send(2'd2, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1);
        send(2'd1, 16'h9000, 16'h9000, 1'b0, 1'b1, 1'b1);
        drain();

        // counter saturation at 0xFFFF, then clear beats increment
        cfg_write(2'd0, 16'h0000, 16'h2000, 1'b0);
        for (int i = 0; i < 65535; i++) send(2'd0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        drain();
        chk_cnt(2'd0, 16'hFFFF, "cnt_ch0_full");
        send(2'd0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        drain();
        chk_cnt(2'd0, 16'hFFFF, "cnt_ch0_hold");
        sat_sel = 2'd0;
        send(2'd0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        g = 0;
        #1;
        while (!out_valid && g < 20) begin
            @(negedge clock);
            #1;
            g++;
        end
        chk("clr_wait_out_valid", 32'(out_valid), 32'd1);
        sat_clear = 1'b1;
        @(negedge clock);
        sat_clear = 1'b0;
        #1;
        chk("cnt_clear_wins", 32'(sat_count), 32'd0);
        @(negedge clock);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
